serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Parallel-to-serial converter; the transmit-side counterpart of the team's deserializer.
- Accepts one parallel word plus a bit count, then emits the bits MSB-first, one bit per clock, each with a valid strobe.
- Asserts busy while shifting and ignores new requests until the current word is done.
- Sits between a packet/word source and a serial link or the deserializer under loopback test.

Parameters:
- DATA_W, 16, parallel input width; must be a power of two and at least 4.
- MOD_W, $clog2(DATA_W), width of data_mod_i; derived, do not override.

Ports:
- clk_i  input  1  single clock; all logic is on the rising edge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_W  parallel word to send.
- data_mod_i  input  MOD_W  number of MSBs to send; 0 means all DATA_W bits.
- data_val_i  input  1  request strobe, qualifies data_i and data_mod_i.
- ser_data_o  output  1  serial bit.
- ser_data_val_o  output  1  ser_data_o valid.
- busy_o  output  1  high while a word is being shifted; requests are ignored.

Behaviour:
- Reset (srst_i=1 at a clock edge) forces ser_data_o=0, ser_data_val_o=0, busy_o=0, FSM=IDLE and counter=0.
- Reset has priority over every other event, including mid-word; the word being shifted is dropped with no further valid bits.
- Bit count N:
  - data_mod_i=0 gives N=DATA_W.
  - data_mod_i=1 or 2 is an illegal length: the request is ignored (no output, busy stays 0).
  - data_mod_i=3..DATA_W-1 gives N=data_mod_i.
- Accept condition: data_val_i=1 and busy_o=0 and N legal. On an accepted edge, capture data_i into the shift register and N into the counter.
- Latency: the first bit appears on the cycle after acceptance.
- Output sequence: ser_data_o = data_i[DATA_W-1], then data_i[DATA_W-2], and so on, for N consecutive cycles with ser_data_val_o=1. There are no gaps.
- busy_o is registered. It is high on exactly the N output cycles and low otherwise.
- Back-to-back: a request on the last bit cycle is ignored (busy_o=1). The earliest new accept is the first cycle with busy_o=0, so the minimum gap between words is 1 idle cycle.
- data_val_i while busy_o=1 is dropped silently. It has no effect on the current word, and the captured data is never altered.
- ser_data_o is 0 whenever ser_data_val_o=0.
- FSM:
  - IDLE: on accept, go to SHIFT.
  - SHIFT: each cycle, output the MSB of the shift register, shift left by 1 and decrement the counter. When the counter reaches 1 and that bit has been output, go to IDLE.
- Unused LSBs, when N<DATA_W, are never output.
- Counter width is MOD_W+1 so that it can hold DATA_W.

Optional Feature:
- Macro: SERIALIZER_LSB_FIRST_EN.
- When defined, bit order is LSB-first: data_i[0], data_i[1], and so on, up to data_i[N-1]. The shift register shifts right. All timing, busy and length rules are unchanged.
- When undefined, the order is MSB-first as specified above.

Test Plan:
- Full word: data_i=16'hA5C3, data_mod_i=0, one-cycle data_val_i -> bits 1010010111000011 on 16 consecutive cycles starting the next cycle, busy_o high for exactly those 16 cycles.
- Partial word: data_i=16'hF000, data_mod_i=5 -> bits 11110, busy_o high 5 cycles, then ser_data_val_o=0 and ser_data_o=0.
- Illegal length: data_mod_i=1, and separately data_mod_i=2, with data_val_i=1 -> no ser_data_val_o and busy_o stays 0. A following legal request is accepted normally.
- Request while busy: start 16'hFFFF with mod 0, then pulse data_val_i with 16'h0000 on cycle 4 and on the last bit cycle -> the output is 16 ones only and no second word is sent. A request 1 cycle after busy_o falls is accepted.
- Reset mid-word: start 16'hAAAA with mod 0 and assert srst_i on the 7th bit cycle -> all outputs are 0 on the next cycle and stay 0. A post-reset request with 16'h8001, mod 0 yields 1, then 14 zeros, then 1.
- Random: 1000 random data/mod/val, including val held high continuously, checked against a reference model of bit order, count, busy_o window and the ignore rules. Run with and without SERIALIZER_LSB_FIRST_EN.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial converter: one word in, N bits out (MSB-first), one bit per clock with a valid strobe.
// Define SERIALIZER_LSB_FIRST_EN to send LSB-first instead; timing, busy and length rules are identical.
module serializer #(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [MOD_W:0]    cnt, cnt_nxt;
  logic [MOD_W:0]    n_req;
  logic              legal, accept, last;
  logic              bit_nxt, val_nxt, busy_nxt;

  // Lengths 1 and 2 are rejected; 0 encodes a full word.
  always_comb begin
    n_req  = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
    legal  = (data_mod_i == '0) || (data_mod_i >= MOD_W'(3));
    accept = data_val_i && !busy_o && legal && (state == IDLE);
    last   = (cnt == (MOD_W+1)'(1));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      cnt            <= cnt_nxt;
      ser_data_o     <= bit_nxt;
      ser_data_val_o <= val_nxt;
      busy_o         <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first bit is registered on the accept edge so it appears on the very next cycle.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    bit_nxt   = 1'b0;
    val_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SERIALIZER_LSB_FIRST_EN
          bit_nxt   = data_i[0];
          shreg_nxt = data_i >> 1;
`else
          bit_nxt   = data_i[DATA_W-1];
          shreg_nxt = data_i << 1;
`endif
          cnt_nxt   = n_req;
          val_nxt   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
          bit_nxt   = shreg[0];
          shreg_nxt = shreg >> 1;
`else
          bit_nxt   = shreg[DATA_W-1];
          shreg_nxt = shreg << 1;
`endif
          cnt_nxt   = cnt - (MOD_W+1)'(1);
          val_nxt   = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed scenarios plus random traffic against a queue-based model.
// Build with SERIALIZER_LSB_FIRST_EN defined to check the LSB-first variant.
module tb_serializer;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] data;
  logic [3:0]  data_mod;
  logic        data_val;
  logic        ser_data;
  logic        ser_data_val;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // model: bits still to come, and what should be on the outputs now
  bit exp_q[$];
  bit cur_v = 1'b0;
  bit cur_b = 1'b0;

  logic [15:0] coll;
  int          coll_n;

  serializer #(.DATA_W(16)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (data_mod),
    .data_val_i     (data_val),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_data_val),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input bit val, input logic [15:0] d, input logic [3:0] m);
    int n;
    if (rst) begin
      exp_q.delete();
      cur_v = 1'b0;
      cur_b = 1'b0;
    end else begin
      if (!cur_v && val && (m == 0 || m >= 3)) begin
        n = (m == 0) ? 16 : int'(m);
        for (int i = 0; i < n; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
          exp_q.push_back(d[i]);
`else
          exp_q.push_back(d[15-i]);
`endif
        end
      end
      if (exp_q.size() > 0) begin
        cur_b = exp_q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
        cur_b = 1'b0;
      end
    end
  endtask

  task automatic clear_coll();
    coll   = '0;
    coll_n = 0;
  endtask

  // one clock: drive at negedge, model at posedge, check at next negedge
  task automatic step(input bit rst, input bit val, input logic [15:0] d, input logic [3:0] m);
    srst     = rst;
    data_val = val;
    data     = d;
    data_mod = m;
    @(posedge clk);
    model_edge(rst, val, d, m);
    @(negedge clk);
    check("val", {31'b0, ser_data_val}, {31'b0, cur_v});
    check("bit", {31'b0, ser_data}, {31'b0, cur_v & cur_b});
    check("busy", {31'b0, busy}, {31'b0, cur_v});
    if (ser_data_val) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      if (coll_n < 16) coll[coll_n] = ser_data;
`else
      coll = {coll[14:0], ser_data};
`endif
      coll_n++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    bit hold;
    bit rv;
    srst = 1'b1; data_val = 1'b0; data = '0; data_mod = '0;
    clear_coll();
    @(negedge clk);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'hFFFF, 4'h0);
    check("reset_val", {31'b0, ser_data_val}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);

    // full word
    clear_coll();
    step(1'b0, 1'b1, 16'hA5C3, 4'h0);
    check("full_first_busy", {31'b0, busy}, 32'd1);
    idle(18);
    check("full_count", coll_n, 32'd16);
    check("full_word", {16'b0, coll}, 32'hA5C3);

    // partial word
    clear_coll();
    step(1'b0, 1'b1, 16'hF000, 4'd5);
    idle(7);
    check("part_count", coll_n, 32'd5);
`ifdef SERIALIZER_LSB_FIRST_EN
    check("part_word", {16'b0, coll}, 32'h0000);
`else
    check("part_word", {16'b0, coll}, 32'h001E);
`endif

    // illegal lengths, then a legal one
    clear_coll();
    step(1'b0, 1'b1, 16'hFFFF, 4'd1);
    check("illegal1_busy", {31'b0, busy}, 32'd0);
    step(1'b0, 1'b1, 16'hFFFF, 4'd2);
    check("illegal2_busy", {31'b0, busy}, 32'd0);
    idle(2);
    check("illegal_count", coll_n, 32'd0);
    step(1'b0, 1'b1, 16'h9000, 4'd3);
    idle(4);
    check("legal3_count", coll_n, 32'd3);

    // requests while busy are dropped
    clear_coll();
    step(1'b0, 1'b1, 16'hFFFF, 4'h0);
    for (int k = 1; k <= 16; k++)
      step(1'b0, (k == 4 || k == 16), 16'h0000, 4'h0);
    check("busy_drop_count", coll_n, 32'd16);
    check("busy_drop_word", {16'b0, coll}, 32'hFFFF);
    check("busy_low_after", {31'b0, busy}, 32'd0);
    step(1'b0, 1'b1, 16'h0F0F, 4'd8);
    check("reaccept_busy", {31'b0, busy}, 32'd1);
    idle(10);

    // reset mid-word on the 7th bit cycle
    clear_coll();
    step(1'b0, 1'b1, 16'hAAAA, 4'h0);
    idle(6);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    check("rst_mid_val", {31'b0, ser_data_val}, 32'd0);
    idle(12);
    check("rst_mid_count", coll_n, 32'd7);
    clear_coll();
    step(1'b0, 1'b1, 16'h8001, 4'h0);
    idle(17);
    check("post_rst_count", coll_n, 32'd16);
    check("post_rst_word", {16'b0, coll}, 32'h8001);

    // random traffic, with stretches of data_val held high
    hold = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 50 == 0) hold = ($urandom_range(0, 3) == 0);
      rv = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 199) == 0), rv, 16'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
